// File: rtl/clksw_pkg.sv
// Shared definitions for the phase-1 clock switch and its sequencer.
package clksw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TO_LS,
    ST_SET_DIV,
    ST_TO_HS
  } state_t;

  // CPU clock divider encodings, shared with the switch instance.
  localparam logic [1:0] DIV_1 = 2'b00;
  localparam logic [1:0] DIV_2 = 2'b01;
  localparam logic [1:0] DIV_4 = 2'b10;
  localparam logic [1:0] DIV_8 = 2'b11;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DIV_SETTLE  = 4;
  localparam int DEF_TIMEOUT     = 255;

  // An LS target matches LS regardless of divider; HS targets must match divider too.
  function automatic logic same_mode(input logic hs_a, input logic [1:0] div_a,
                                     input logic hs_b, input logic [1:0] div_b);
    return (hs_a == hs_b) && (!hs_a || (div_a == div_b));
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser with synchronous reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clksw_sequencer.sv
// Steps the clock switch between LS and HS; the divider only moves while LS drives the CPU.
module clksw_sequencer
  import clksw_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DIV_SETTLE  = DEF_DIV_SETTLE,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic       lsclk_in,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_hs,
  input  logic [1:0] req_div,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       cur_hs,
  output logic [1:0] cur_div,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] SETTLE_LAST = 8'(DIV_SETTLE);
  // Abort on the edge at which the wait count would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       tgt_hs;
  logic [1:0] tgt_div;
  logic       hs_ack;
  logic       ls_ack;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk (lsclk_in),
    .rst (rst),
    .d   (hsclk_selected),
    .q   (hs_ack)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ls (
    .clk (lsclk_in),
    .rst (rst),
    .d   (lsclk_selected),
    .q   (ls_ack)
  );

  always_ff @(posedge lsclk_in) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      tgt_hs         <= 1'b0;
      tgt_div        <= DIV_1;
      hsclk_sel      <= 1'b0;
      cpuclk_div_sel <= DIV_1;
      cur_hs         <= 1'b0;
      cur_div        <= DIV_1;
      err            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tgt_hs  <= req_hs;
            tgt_div <= req_div;
            err     <= 1'b0;
            cnt     <= '0;
            if (!same_mode(req_hs, req_div, cur_hs, cur_div)) begin
              if (cur_hs) begin
                state     <= ST_TO_LS;
                hsclk_sel <= 1'b0;
              end else begin
                state <= ST_SET_DIV;
              end
            end
          end
        end

        ST_TO_LS: begin
          if (ls_ack && !hs_ack) begin
            cnt <= '0;
            if (tgt_hs) begin
              state <= ST_SET_DIV;
            end else begin
              state  <= ST_IDLE;
              cur_hs <= 1'b0;
            end
          end else if (cnt == TMO_LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hsclk_sel <= 1'b0;
            err       <= 1'b1;
            cur_hs    <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_SET_DIV: begin
          cpuclk_div_sel <= tgt_div;
          if (cnt == SETTLE_LAST) begin
            state     <= ST_TO_HS;
            cnt       <= '0;
            hsclk_sel <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_TO_HS: begin
          if (hs_ack && !ls_ack) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_hs  <= 1'b1;
            cur_div <= cpuclk_div_sel;
          end else if (cnt == TMO_LAST) begin
            // The switch itself guards the glitch-free handover, so fall back without waiting.
            state     <= ST_IDLE;
            cnt       <= '0;
            hsclk_sel <= 1'b0;
            err       <= 1'b1;
            cur_hs    <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: doc/clksw_sequencer.md
# clksw_sequencer

Sequencer that owns the `hsclk_sel` and `cpuclk_div_sel` controls of the phase-1 clock switch. It accepts speed-change requests from the CPU-side register decode and steps the switch through safe transitions. The divider select only ever changes while the low-speed clock is driving the CPU. It runs in the low-speed host clock domain, synchronises the switch's `hsclk_selected` / `lsclk_selected` acknowledges, and falls back to low speed on timeout.

## Interface
- `SYNC_STAGES`, 2, flops in each acknowledge synchroniser (≥2).
- `DIV_SETTLE`, 4, lsclk cycles to hold in SET_DIV after driving a new divider value.
- `TIMEOUT`, 255, lsclk cycles to wait for an acknowledge before aborting (8-bit counter, 1..255).
- `lsclk_in`  in  1  block clock (host low-speed clock).
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  speed-change request.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_hs`  in  1  1 = run from high-speed clock, 0 = low speed.
- `req_div`  in  2  divider for HS mode: 00 /1, 01 /2, 10 /4, 11 /8 (ignored when `req_hs`=0).
- `hsclk_selected`  in  1  async acknowledge from switch (cpuclk domain).
- `lsclk_selected`  in  1  async acknowledge from switch (lsclk domain, still synchronised).
- `hsclk_sel`  out  1  to switch; registered.
- `cpuclk_div_sel`  out  2  to switch; registered.
- `cur_hs`  out  1  committed mode: 1 = HS confirmed running.
- `cur_div`  out  2  committed divider.
- `busy`  out  1  transition in progress.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, TO_LS, SET_DIV, TO_HS.
- Acknowledge inputs pass through SYNC_STAGES flops; FSM uses only the synchronised `hs_ack` / `ls_ack`.
- `req_ready` = 1 only in IDLE. Acceptance latches `req_hs` / `req_div` into target registers and clears `err`.
- Acceptance from IDLE:
  - Target equals committed mode (same `req_hs`; same `req_div` when HS) → stay IDLE, no output change. A redundant LS request with `cur_hs`=0 counts as equal.
  - Currently HS (`cur_hs`=1) → TO_LS, `hsclk_sel`←0.
  - Currently LS and target HS → SET_DIV.
- TO_LS: wait for `ls_ack`=1 and `hs_ack`=0.
  - Then: target LS → IDLE with `cur_hs`←0; target HS → SET_DIV.
- SET_DIV: `cpuclk_div_sel`←target div on entry; hold DIV_SETTLE cycles, `hsclk_sel` remains 0; then TO_HS, `hsclk_sel`←1.
- TO_HS: wait for `hs_ack`=1 and `ls_ack`=0; then IDLE with `cur_hs`←1 and `cur_div`←`cpuclk_div_sel`.
- Timeout counter clears on every state entry and increments in TO_LS and TO_HS. When it reaches TIMEOUT:
  - `hsclk_sel`←0, `err`←1, `cur_hs`←0.
  - Next state is IDLE, even if LS is not yet acknowledged (the switch itself enforces safety).
- `cpuclk_div_sel` changes only in SET_DIV, which is only reachable with `hsclk_sel`=0 and LS acknowledged or never left.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `hsclk_sel`=0, `cpuclk_div_sel`=00, `cur_hs`=0, `cur_div`=00, `busy`=0, `err`=0, `req_ready`=1, synchronisers 0, counter 0. Reset mid-transition aborts immediately to these values.
- Acceptance at edge N:
  - HS→LS: `hsclk_sel` low after edge N, `busy` high after edge N.
  - LS→HS: enter SET_DIV at edge N, `cpuclk_div_sel` valid after N+1, `hsclk_sel` high after N+1+DIV_SETTLE.
- Acknowledge latency: SYNC_STAGES cycles plus one FSM cycle to leave the wait state.
- `req_valid` outside IDLE is ignored (`req_ready`=0). The requester holds `req_valid` until accepted.

## Structure
- Shared package `clksw_pkg`:
  - state enum;
  - divider encoding constants DIV_1/2/4/8 = 00/01/10/11, also used by the switch instance;
  - default DIV_SETTLE and TIMEOUT values.
- Sub-module `sync_ff` (parameter STAGES), instantiated once per acknowledge input.

## Test plan
- Reset release, model switch acking after 3 cycles; request HS/div 01 → `cpuclk_div_sel`=01 while `hsclk_sel`=0 for 4 cycles, then `hsclk_sel`=1; IDLE with `cur_hs`=1, `cur_div`=01; `err`=0.
- From HS/01, request HS/11 → `hsclk_sel` 1→0, wait `ls_ack`, div becomes 11 only after `ls_ack`, then `hsclk_sel`=1; `cur_div`=11.
- From HS/11, request LS → `hsclk_sel`=0, `cur_hs`=0 after `ls_ack`; `cpuclk_div_sel` stays 11.
- Redundant request HS/11 while in HS/11 → no output change; `busy` stays 0; `req_ready` stays 1.
- Model never asserts `hs_ack`, request HS/00 → after 255 cycles in TO_HS: `hsclk_sel`=0, `err`=1, IDLE; next accepted request clears `err`.
- Assert `rst` during SET_DIV → next cycle all outputs at reset values; `req_valid` held high during a transition is not accepted until IDLE.
